hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Unified stall + forwarding controller for the 5-stage MIPS pipeline, replacing per-stage decoders.
//  Tracks in-flight writers in E/M/W with a countdown Tnew per slot.
//  Drives the D-stage stall and forward selects for D and E read ports.
//  Adds a multi-cycle mult/div busy counter; NUM_RD read ports per instruction.
// PARAMETERS
//  NUM_RD    2   read ports per instruction (rs, rt, ...)
//  TW        2   width of Tnew/Tuse fields
//  MULT_LAT  5   cycles md unit is busy after a mult issues
//  DIV_LAT   10  cycles md unit is busy after a div issues
//  CW        4   md counter width; must hold max(MULT_LAT, DIV_LAT)
// PORTS
//  clk        in   1          clock; all state on rising edge
//  reset      in   1          synchronous, active-high; clears all state
//  d_ra       in   NUM_RD*5   D-stage source reg numbers, port i at [5i+4:5i]
//  d_ruse     in   NUM_RD     port i actually reads its register
//  d_tuse     in   NUM_RD*TW  cycles until port i value is needed (0 = in D)
//  d_we       in   1          D instruction writes GRF
//  d_wa       in   5          D destination register
//  d_tnew     in   TW         cycles after entering E until result exists (ALU 1, load 2, link 0)
//  d_md_op    in   1          D instruction uses the md unit (mult/div/mfhi/mflo/mthi/mtlo)
//  d_md_start in   1          D instruction starts a mult/div operation
//  d_md_div   in   1          start is a divide (selects DIV_LAT)
//  stall      out  1          hold F/D, insert bubble into E
//  fwd_d_sel  out  NUM_RD*2   D-port source: 0 GRF, 1 E, 2 M, 3 W
//  fwd_e_sel  out  NUM_RD*2   E-port source: 0 pipeline reg, 2 M, 3 W
//  md_busy    out  1          md counter nonzero
// BEHAVIOUR
//  Slots: E, M, W; each holds valid, we, wa, tnew. E also holds ra[NUM_RD] and ruse.
//  Each edge: W<=M, M<=E, tnew saturating-decrements by 1 on each advance.
//  E takes the D instruction when !stall, otherwise a bubble (valid=0).
//  Writer match for port i: slot valid && we && wa==ra_i && wa!=0 && ruse_i.
//  D sel for port i:
//   - take the youngest match (E before M before W);
//   - sel = stage code if that slot's tnew==0, else 0 (later E-stage forwarding picks it up).
//  Stall term for port i: the youngest match has tnew > tuse_i. Older matches are ignored.
//  E sel for port i: same rule against M, W only, using E.ra_i; 0 if no ready match.
//  A non-ready youngest match never falls through to an older slot.
//  md counter cnt (CW bits): on edge with d_md_start && !stall, cnt <= d_md_div ? DIV_LAT : MULT_LAT.
//   Otherwise cnt decrements when nonzero. md_busy = (cnt!=0).
//  stall = any port stall term || (d_md_op && md_busy).
//  All outputs are combinational from slots + D inputs; zero latency.
//  Stall takes priority over start: a stalled start does not load cnt.
//  Reset: slots invalid, cnt=0. Hence stall=0, md_busy=0, all sel=0 while reset is held and after it.
//  Reset mid-divide aborts the count; the first md op after reset proceeds immediately.
//  Register $0 never matches. Duplicate ra across ports is evaluated independently.
// STRUCTURE
//  Shared package hazard_pkg:
//   - FWD_GRF/FWD_E/FWD_M/FWD_W select codes;
//   - TNEW_ALU=1, TNEW_DM=2, TNEW_PC=0;
//   - slot struct {valid, we, wa, tnew}.
//  Sub-module hazard_port_match: one read port vs slot list -> {sel, stall_term}; instanced 2*NUM_RD times (D and E).
//  Top: slot shift register + md counter + OR reduction.
// TESTING
//  1. addu $3 then addu $4,$3 (tuse 1): no stall; next cycle fwd_d_sel=1 is invalid (tnew 1); E issue, then fwd_e_sel=2.
//  2. lw $5 (tnew 2) then beq $5 (tuse 0): stall 2 cycles; a bubble enters E each cycle; then fwd_d_sel=3, stall=0.
//  3. jal (wa 31, tnew 0) then jr $31 (tuse 0): no stall, fwd_d_sel=1 immediately.
//  4. div (DIV_LAT 10) followed by mflo: md_busy high 10 cycles, stall for 10 cycles, mflo issues on cycle 11.
//  5. Write to $0 then read $0: sel=0, stall=0. Same reg written in E and M: E wins.
//  6. Assert reset with cnt=7 and lw in E: next cycle stall=0, md_busy=0, all sel=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: forward select codes,
// standard Tnew values and the in-flight writer slot record.
package hazard_pkg;

    // Forward source codes driven on fwd_d_sel / fwd_e_sel
    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    // Cycles after entering E until the result exists
    localparam logic [1:0] TNEW_PC  = 2'd0;
    localparam logic [1:0] TNEW_ALU = 2'd1;
    localparam logic [1:0] TNEW_DM  = 2'd2;

    // Width of the tnew field stored in each slot
    localparam int unsigned SLOT_TW = 2;

    typedef struct packed {
        logic               valid;
        logic               we;
        logic [4:0]         wa;
        logic [SLOT_TW-1:0] tnew;
    } slot_t;

    // Saturating decrement applied as a writer advances one stage
    function automatic logic [SLOT_TW-1:0] tnew_dec(input logic [SLOT_TW-1:0] t);
        return (t == '0) ? '0 : t - SLOT_TW'(1);
    endfunction

endpackage

// File: rtl/hazard_port_match.sv
// One read port checked against an ordered list of in-flight writer slots
// (index 0 = youngest). Produces the forward select and the stall term.
module hazard_port_match
    import hazard_pkg::*;
#(
    parameter int unsigned NSLOT = 3,
    parameter int unsigned TW    = SLOT_TW
) (
    input  logic [4:0]         ra_i,
    input  logic               ruse_i,
    input  logic [TW-1:0]      tuse_i,
    input  slot_t [NSLOT-1:0]  slots_i,
    input  logic [2*NSLOT-1:0] codes_i,
    output logic [1:0]         sel_o,
    output logic               stall_o
);

    logic found;

    // Only the youngest matching writer counts; an unready one blocks older slots
    always_comb begin
        sel_o   = FWD_GRF;
        stall_o = 1'b0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NSLOT; k++) begin
            if (!found && ruse_i && slots_i[k].valid && slots_i[k].we &&
                (slots_i[k].wa == ra_i) && (slots_i[k].wa != 5'd0)) begin
                found = 1'b1;
                if (slots_i[k].tnew == '0) begin
                    sel_o = codes_i[2*k +: 2];
                end
                stall_o = (TW'(slots_i[k].tnew) > tuse_i);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Unified stall and forwarding controller for the 5-stage pipeline.
// Tracks writers in E/M/W with a Tnew countdown and a mult/div busy counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned TW       = SLOT_TW,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CW       = 4   // must hold max(MULT_LAT, DIV_LAT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*5-1:0]  d_ra,
    input  logic [NUM_RD-1:0]    d_ruse,
    input  logic [NUM_RD*TW-1:0] d_tuse,
    input  logic                 d_we,
    input  logic [4:0]           d_wa,
    input  logic [TW-1:0]        d_tnew,
    input  logic                 d_md_op,
    input  logic                 d_md_start,
    input  logic                 d_md_div,
    output logic                 stall,
    output logic [NUM_RD*2-1:0]  fwd_d_sel,
    output logic [NUM_RD*2-1:0]  fwd_e_sel,
    output logic                 md_busy
);

    slot_t                e_q, e_d, m_q, m_d, w_q, w_d;
    logic [NUM_RD*5-1:0]  e_ra_q, e_ra_d;
    logic [NUM_RD-1:0]    e_ruse_q, e_ruse_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_RD-1:0]    d_stall_terms;
    logic [NUM_RD-1:0]    e_stall_unused;

    slot_t [2:0] d_slots;
    slot_t [1:0] e_slots;

    localparam logic [5:0] D_CODES = {FWD_W, FWD_M, FWD_E};
    localparam logic [3:0] E_CODES = {FWD_W, FWD_M};

    assign d_slots = {w_q, m_q, e_q};
    assign e_slots = {w_q, m_q};

    assign md_busy = (cnt_q != '0);
    assign stall   = (|d_stall_terms) || (d_md_op && md_busy);

    // Per-port matchers: D ports see E/M/W, E ports see M/W
    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        hazard_port_match #(.NSLOT(3), .TW(TW)) u_d_match (
            .ra_i    (d_ra[5*i +: 5]),
            .ruse_i  (d_ruse[i]),
            .tuse_i  (d_tuse[TW*i +: TW]),
            .slots_i (d_slots),
            .codes_i (D_CODES),
            .sel_o   (fwd_d_sel[2*i +: 2]),
            .stall_o (d_stall_terms[i])
        );

        hazard_port_match #(.NSLOT(2), .TW(TW)) u_e_match (
            .ra_i    (e_ra_q[5*i +: 5]),
            .ruse_i  (e_ruse_q[i]),
            .tuse_i  ('0),
            .slots_i (e_slots),
            .codes_i (E_CODES),
            .sel_o   (fwd_e_sel[2*i +: 2]),
            .stall_o (e_stall_unused[i])
        );
    end

    // Next slot contents and md counter; a stall injects a bubble into E
    always_comb begin
        e_d      = '0;
        e_ra_d   = '0;
        e_ruse_d = '0;
        if (!stall) begin
            e_d.valid = 1'b1;
            e_d.we    = d_we;
            e_d.wa    = d_wa;
            e_d.tnew  = SLOT_TW'(d_tnew);
            e_ra_d    = d_ra;
            e_ruse_d  = d_ruse;
        end

        m_d      = e_q;
        m_d.tnew = tnew_dec(e_q.tnew);
        w_d      = m_q;
        w_d.tnew = tnew_dec(m_q.tnew);

        cnt_d = cnt_q;
        if (d_md_start && !stall) begin
            cnt_d = d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Slot shift register and md counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            e_ra_q   <= '0;
            e_ruse_q <= '0;
            cnt_q    <= '0;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            w_q      <= w_d;
            e_ra_q   <= e_ra_d;
            e_ruse_q <= e_ruse_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
